// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - line-fill/write-back bus between cache and memory responder
//
// Purpose: bundles the request/response signals of one 128-bit line transaction.
// Signals:
//   mem_req    requester -> memory  transaction request, held until mem_ready
//   mem_we     requester -> memory  0 = line read, 1 = line write
//   mem_addr   requester -> memory  byte address (line index taken from bits above [3:0])
//   mem_wdata  requester -> memory  write line data
//   mem_rdata  memory -> requester  read line data, valid with mem_ready
//   mem_ready  memory -> requester  one-cycle completion pulse
//   busy       memory -> requester  transaction in flight
// Modports: master = requester (cache side), slave = memory responder.

interface line_mem_responder_if;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         busy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, busy
    );
endinterface

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency 128-bit line memory responder with transaction counters
//
// Purpose: main-memory model behind the 2-way cache. Accepts one line read or
// write, completes it LATENCY cycles after acceptance with a one-cycle
// mem_ready pulse, and keeps saturating read/write completion counters.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       line_mem_responder_if.slave (mem_req/we/addr/wdata in,
//             mem_rdata/mem_ready/busy out)
//   rd_count  completed reads, saturating
//   wr_count  completed writes, saturating

module line_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    line_mem_responder_if.slave     bus,
    output logic [CNT_W-1:0]        rd_count,
    output logic [CNT_W-1:0]        wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0]       LAT_M1  = 8'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            rdata_q;
    logic [CNT_W-1:0]        rd_cnt_q, wr_cnt_q;
    logic                    do_access;

    logic [127:0]            mem [0:(1<<DEPTH_LOG2)-1];

    // Request fields are captured only in IDLE, so later changes on the bus
    // cannot disturb a transaction in flight.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    we_d    = bus.mem_we;
                    idx_d   = bus.mem_addr[DEPTH_LOG2+3:4];
                    wdata_d = bus.mem_wdata;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            if (do_access && !we_q) begin
                rdata_q <= mem[idx_q];
                if (rd_cnt_q != CNT_MAX) begin
                    rd_cnt_q <= rd_cnt_q + CNT_ONE;
                end
            end
            if (do_access && we_q && (wr_cnt_q != CNT_MAX)) begin
                wr_cnt_q <= wr_cnt_q + CNT_ONE;
            end
        end
    end

    // Storage is not reset; an async reset forces IDLE, so an aborted
    // transaction never reaches the write below.
    always_ff @(posedge clk) begin
        if (!rst && do_access && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_ready = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_rdata = rdata_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - scoreboard testbench for line_mem_responder

module tb_line_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
    } exp_t;

    localparam logic [127:0] D_0123 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D_AAAA = {4{32'hAAAA_AAAA}};
    localparam logic [127:0] D_9999 = {4{32'h9999_9999}};
    localparam logic [127:0] D_2222 = {4{32'h2222_2222}};
    localparam logic [127:0] D_3333 = {4{32'h3333_3333}};
    localparam logic [127:0] D_1111 = {4{32'h1111_1111}};
    localparam logic [127:0] D_FFFF = {4{32'hFFFF_FFFF}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [15:0] rd_count, wr_count;
    logic [3:0]  rd_count_s, wr_count_s;

    line_mem_responder_if bus ();
    line_mem_responder_if bus_s ();

    line_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    line_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT), .CNT_W(4)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_s),
        .rd_count (rd_count_s),
        .wr_count (wr_count_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: expected responses and deferred scalar checks.
    exp_t         rq[$];
    string        name_q[$];
    logic [127:0] act_q[$];
    logic [127:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] model_rd = '0;
    int           n_rd = 0;
    int           n_wr = 0;
    exp_t         e_m;

    task automatic do_check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic post(input string name, input logic [127:0] act, input logic [127:0] exp);
        name_q.push_back(name);
        act_q.push_back(act);
        exp_q.push_back(exp);
    endtask

    // Monitor: the only process that evaluates comparisons.
    always @(negedge clk) begin
        if (bus.mem_ready) begin
            if (rq.size() == 0) begin
                do_check("unexpected_ready", 128'd1, 128'd0);
            end else begin
                e_m = rq.pop_front();
                do_check("ready_cycle", 128'(cyc), 128'(e_m.cyc));
                do_check("rdata", bus.mem_rdata, e_m.rdata);
            end
        end
        while (name_q.size() > 0) begin
            do_check(name_q.pop_front(), act_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp_rd, input bit scramble);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        e.cyc = cyc + 1 + LAT;
        if (!we) model_rd = exp_rd;
        e.rdata = model_rd;
        rq.push_back(e);
        if (we) n_wr++; else n_rd++;
        for (int i = 0; i < LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (scramble && i == 0) begin
                bus.mem_we    = ~we;
                bus.mem_addr  = 32'h0000_0090;
                bus.mem_wdata = {4{32'h5555_5555}};
            end
            if (bus.mem_ready) seen = 1'b1;
        end
        if (!seen) post("ready_timeout", 128'd0, 128'd1);
        bus.mem_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic sat_txn(input logic we);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus_s.mem_req   = 1'b1;
        bus_s.mem_we    = we;
        bus_s.mem_addr  = 32'h0;
        bus_s.mem_wdata = {4{32'hC0DE_0000}};
        for (int i = 0; i < LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_s.mem_ready) seen = 1'b1;
        end
        if (!seen) post("sat_ready_timeout", 128'd0, 128'd1);
        bus_s.mem_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus_s.mem_req = 1'b0; bus_s.mem_we = 1'b0; bus_s.mem_addr = '0; bus_s.mem_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        post("reset_ready", 128'(bus.mem_ready), 128'd0);
        post("reset_busy", 128'(bus.busy), 128'd0);
        post("reset_rdata", bus.mem_rdata, 128'd0);
        post("reset_rd_count", 128'(rd_count), 128'd0);
        post("reset_wr_count", 128'(wr_count), 128'd0);

        // Basic write then read of idx 5.
        txn(1'b1, 32'h0000_0050, D_0123, '0, 1'b0);
        txn(1'b0, 32'h0000_0050, '0, D_0123, 1'b0);
        post("basic_wr_count", 128'(wr_count), 128'd1);
        post("basic_rd_count", 128'(rd_count), 128'd1);

        // Aliasing: 0x4010 and 0x0010 both map to idx 1.
        txn(1'b1, 32'h0000_4010, D_AAAA, '0, 1'b0);
        txn(1'b0, 32'h0000_0010, '0, D_AAAA, 1'b0);

        // Inputs changed after acceptance of a write to idx 2.
        txn(1'b1, 32'h0000_0090, D_9999, '0, 1'b0);
        txn(1'b1, 32'h0000_0020, D_2222, '0, 1'b1);
        txn(1'b0, 32'h0000_0020, '0, D_2222, 1'b0);
        txn(1'b0, 32'h0000_0090, '0, D_9999, 1'b0);

        // Back-to-back reads of idx 3 with mem_req held high.
        txn(1'b1, 32'h0000_0030, D_3333, '0, 1'b0);
        @(negedge clk);
        c = cyc;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0000_0030;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.cyc   = c + 1 + LAT + k * (LAT + 2);
            e.rdata = D_3333;
            rq.push_back(e);
        end
        n_rd += 3;
        model_rd = D_3333;
        for (int k = 0; k < 3 * (LAT + 2); k++) begin
            @(negedge clk);
            post("b2b_busy", 128'(bus.busy), ((k % (LAT + 2)) == LAT + 1) ? 128'd0 : 128'd1);
            if (k == 2 * (LAT + 2)) bus.mem_req = 1'b0;
        end
        post("b2b_rd_count", 128'(rd_count), 128'(n_rd));

        // Reset during WAIT of a write to idx 7.
        txn(1'b1, 32'h0000_0070, D_1111, '0, 1'b0);
        post("pre_rst_wr_count", 128'(wr_count), 128'(n_wr));
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h0000_0070; bus.mem_wdata = D_FFFF;
        @(negedge clk);
        bus.mem_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_rd = 0; n_wr = 0; model_rd = '0;
        post("rst_rd_count", 128'(rd_count), 128'd0);
        post("rst_wr_count", 128'(wr_count), 128'd0);
        post("rst_busy", 128'(bus.busy), 128'd0);
        post("rst_rdata", bus.mem_rdata, 128'd0);
        repeat (LAT + 4) @(negedge clk);
        txn(1'b0, 32'h0000_0070, '0, D_1111, 1'b0);
        post("post_rst_rd_count", 128'(rd_count), 128'd1);
        post("post_rst_wr_count", 128'(wr_count), 128'd0);

        // Saturation on the 4-bit-counter instance.
        sat_txn(1'b1);
        for (int i = 1; i <= 17; i++) begin
            sat_txn(1'b0);
            post("sat_rd_count", 128'(rd_count_s), (i > 15) ? 128'd15 : 128'(i));
        end
        post("sat_wr_count", 128'(wr_count_s), 128'd1);

        repeat (LAT + 4) @(negedge clk);
        post("pending_responses", 128'(rq.size()), 128'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
